read_ptr_sync: RTL
==================

# read_ptr_sync

Read-clock-domain pointer stage of the asynchronous FIFO. It sits directly upstream of `read_fifo_ctrl`. It synchronizes the Gray-coded write pointer from the write domain and decodes it to binary for `read_fifo_ctrl.w_ptr_in`. It also owns the binary read pointer that drives `read_fifo_ctrl.r_ptr_in`, and the Gray read pointer sent back to the write domain. It additionally provides a read strobe, an occupancy level and a sticky synchronizer-integrity flag.

## Interface
- `ADDR_WIDTH`, default 3, pointer and address width. Pointers carry no extra wrap bit; "equal" means empty, matching `read_fifo_ctrl`.
- `SYNC_STAGES`, default 2, number of synchronizer flops. Legal values are 2 and above.

- `r_clk_in`, input, 1 bit: read clock. This is the only clock of the block.
- `r_reset_in`, input, 1 bit: reset, asynchronous, active-high.
- `r_request_in`, input, 1 bit: read request from the consumer.
- `ctrl_empty_in`, input, 1 bit: `ctrl_empty_out` from `read_fifo_ctrl`.
- `w_ptr_gray_in`, input, ADDR_WIDTH bits: Gray write pointer, registered in the write domain and asynchronous to `r_clk_in`.
- `w_ptr_out`, output, ADDR_WIDTH bits: synchronized binary write pointer.
- `r_ptr_out`, output, ADDR_WIDTH bits: binary read pointer, also used as the memory read address.
- `r_ptr_gray_out`, output, ADDR_WIDTH bits: registered Gray read pointer sent to the write domain.
- `r_en_out`, output, 1 bit: read strobe.
- `level_out`, output, ADDR_WIDTH bits: entries currently readable.
- `sync_err_out`, output, 1 bit: sticky Gray-violation flag.

## Operation
- **Write-pointer synchronizer:** a chain `sync[0..SYNC_STAGES-1]`, where `sync[0]` samples `w_ptr_gray_in` and each edge shifts the chain.
  - No logic sits between stages.
  - `sync[0]` is the only flop allowed to go metastable.
- **Gray-to-binary decode:** combinational, taken from the last stage `sync[SYNC_STAGES-1]`.
  - bin[MSB] = g[MSB].
  - bin[i] = bin[i+1] XOR g[i].
  - The result drives `w_ptr_out`.
- **Read strobe:** `r_en_out` = `r_request_in` AND NOT `ctrl_empty_in`. It is purely combinational.
  - A request while empty is dropped. It is not queued.
- **Read pointer:** the binary register `r_ptr_out` increments by 1 mod 2^ADDR_WIDTH on every edge where `r_en_out` = 1, and holds otherwise.
  - Wrap-around: 2^ADDR_WIDTH-1 goes to 0.
- **Gray read pointer:** `r_ptr_gray_out` is its own register, loaded with bin2gray(next binary pointer) on the same edge.
  - bin2gray(b) = b XOR (b >> 1).
  - It is never derived combinationally from `r_ptr_out`, so exactly one bit toggles per increment and it is glitch-free for the write-domain synchronizer.
- **Level:** `level_out` = (`w_ptr_out` − `r_ptr_out`) mod 2^ADDR_WIDTH.
  - It is combinational and ADDR_WIDTH bits wide, truncating the borrow.
  - A full FIFO cannot be distinguished from empty here; `read_fifo_ctrl` state resolves that.
- **Integrity check:** register `prev_gray` holds the previous value of the last sync stage.
  - A mismatch is declared when popcount(`sync[last]` XOR `prev_gray`) > 1.
  - `sync_err_out` is set on the edge after the mismatch is present.
  - It stays set until reset.
  - It does not affect pointer behaviour.

## Timing
- **Reset (asynchronous, immediate, also when asserted mid-operation):**
  - All sync stages, `prev_gray`, `r_ptr_out`, `r_ptr_gray_out` and `sync_err_out` go to 0.
  - Therefore `w_ptr_out` = 0 and `level_out` = 0 during reset.
  - `r_en_out` follows its inputs combinationally, even during reset.
- **While `r_reset_in` = 1:** `r_ptr_out` does not increment, regardless of `r_en_out`.
- **Write-pointer latency:** a stable change on `w_ptr_gray_in` appears on `w_ptr_out` after exactly SYNC_STAGES rising edges of `r_clk_in` (2 by default).
- **Read latency:** `r_en_out` high before edge N means `r_ptr_out` and `r_ptr_gray_out` show the new value just after edge N.
- **Simultaneous events:** a write-pointer update arriving and a read on the same edge are independent.
  - `level_out` reflects both after that edge, subject to synchronizer latency.
- **Single-cycle reads:** back-to-back reads are allowed on every cycle while `ctrl_empty_in` = 0.

## Test plan
- **Reset:** hold `r_reset_in` = 1 for 3 edges with `w_ptr_gray_in` = 3'b110 → all outputs 0. Release → `w_ptr_out` = 3'd4 two edges later.
- **Sync latency and decode:** step `w_ptr_gray_in` through 0, 1, 3, 2, 6, 7, 5, 4, holding each 2 cycles → `w_ptr_out` goes 0, 1, 2, 3, 4, 5, 6, 7, each delayed exactly 2 edges. `sync_err_out` stays 0.
- **Read and empty gating:** with `r_request_in` = 1, hold `ctrl_empty_in` = 1 for 2 cycles → `r_en_out` = 0 and `r_ptr_out` stays 0. Then set `ctrl_empty_in` = 0 for 3 cycles → `r_ptr_out` goes 1, 2, 3 and `r_ptr_gray_out` goes 1, 3, 2.
- **Wrap and level:** synced `w_ptr_out` = 2, read continuously from `r_ptr_out` = 5.
  - `level_out` goes 5, 4, 3.
  - `r_ptr_out` wraps 7 → 0 with `r_ptr_gray_out` 4 → 0.
  - `level_out` = 2 at `r_ptr_out` = 0.
- **Integrity:** jump `w_ptr_gray_in` 3'b000 → 3'b011 → `sync_err_out` = 1 three edges after the change (two sync edges plus one compare edge). It stays 1 through later legal steps and clears only on `r_reset_in`.
- **Mid-operation reset:** assert `r_reset_in` asynchronously between edges while reading at `r_ptr_out` = 6 → `r_ptr_out`, `r_ptr_gray_out` and `sync_err_out` go to 0 before the next edge. After release, reads resume from 0.

Source files
------------

// File: rtl/read_ptr_sync.sv
// Read-domain pointer stage of the async FIFO: synchronizes and decodes the Gray write
// pointer, owns the binary/Gray read pointers, and reports level and Gray integrity.
module read_ptr_sync #(
   parameter int unsigned ADDR_WIDTH  = 3,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  r_clk_in,
   input  logic                  r_reset_in,
   input  logic                  r_request_in,
   input  logic                  ctrl_empty_in,
   input  logic [ADDR_WIDTH-1:0] w_ptr_gray_in,
   output logic [ADDR_WIDTH-1:0] w_ptr_out,
   output logic [ADDR_WIDTH-1:0] r_ptr_out,
   output logic [ADDR_WIDTH-1:0] r_ptr_gray_out,
   output logic                  r_en_out,
   output logic [ADDR_WIDTH-1:0] level_out,
   output logic                  sync_err_out
);

   // Stage 0 is the only flop that may go metastable; nothing sits between stages.
   logic [SYNC_STAGES-1:0][ADDR_WIDTH-1:0] sync_q, sync_d;
   logic [ADDR_WIDTH-1:0]                  prev_gray_q, last_gray, gray_diff;
   logic [ADDR_WIDTH-1:0]                  w_ptr_bin;
   logic [ADDR_WIDTH-1:0]                  r_ptr_q, r_ptr_d;
   logic [ADDR_WIDTH-1:0]                  r_ptr_gray_q, r_ptr_gray_d;
   logic                                   sync_err_q, sync_err_d;
   logic                                   gray_mismatch;

   assign last_gray = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], w_ptr_gray_in};
   end

   // bin[i] is the XOR of all Gray bits at or above i.
   always_comb begin
      w_ptr_bin = '0;
      for (int i = 0; i < int'(ADDR_WIDTH); i++) begin
         w_ptr_bin[i] = ^(last_gray >> i);
      end
   end

   always_comb begin
      gray_diff     = last_gray ^ prev_gray_q;
      gray_mismatch = ($countones(gray_diff) > 1);
      sync_err_d    = sync_err_q | gray_mismatch;
   end

   always_comb begin
      r_en_out     = r_request_in & ~ctrl_empty_in;
      r_ptr_d      = r_en_out ? r_ptr_q + ADDR_WIDTH'(1) : r_ptr_q;
      // Registered from the next binary value so the Gray output never glitches.
      r_ptr_gray_d = r_ptr_d ^ (r_ptr_d >> 1);
   end

   always_ff @(posedge r_clk_in or posedge r_reset_in) begin
      if (r_reset_in) begin
         sync_q       <= '0;
         prev_gray_q  <= '0;
         r_ptr_q      <= '0;
         r_ptr_gray_q <= '0;
         sync_err_q   <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         prev_gray_q  <= last_gray;
         r_ptr_q      <= r_ptr_d;
         r_ptr_gray_q <= r_ptr_gray_d;
         sync_err_q   <= sync_err_d;
      end
   end

   assign w_ptr_out      = w_ptr_bin;
   assign r_ptr_out      = r_ptr_q;
   assign r_ptr_gray_out = r_ptr_gray_q;
   assign level_out      = w_ptr_bin - r_ptr_q;
   assign sync_err_out   = sync_err_q;

endmodule
